// File: rtl/shift_writeback_buffer_if.sv
// rtl/shift_writeback_buffer_if.sv - producer, register-file port, bypass and flag signals of the writeback buffer
interface shift_writeback_buffer_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [WIDTH-1:0] in_operand;
  logic [3:0]       in_shamt;
  logic [AW-1:0]    in_dest;
  logic             rf_wstall;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic [AW-1:0]    query_addr;
  logic             query_hit;
  logic [WIDTH-1:0] query_data;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_valid;

  modport master (
    output in_valid, in_result, in_operand, in_shamt, in_dest, rf_wstall, query_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, query_hit, query_data,
    input  flag_z, flag_n, flag_c, flag_valid
  );

  modport slave (
    input  in_valid, in_result, in_operand, in_shamt, in_dest, rf_wstall, query_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, query_hit, query_data,
    output flag_z, flag_n, flag_c, flag_valid
  );
endinterface

// File: rtl/shift_writeback_buffer.sv
// rtl/shift_writeback_buffer.sv - two-entry writeback FIFO with youngest-match bypass lookup
// Define SHIFT_WRITEBACK_FLAGS_EN to build the zero/negative/carry flags of committed results.
module shift_writeback_buffer #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  shift_writeback_buffer_if.slave bus
);
  logic [WIDTH-1:0] mem_result [2];
  logic [AW-1:0]    mem_dest   [2];
  logic [1:0]       count;
  logic             head;
  logic             tail;
  logic             push;
  logic             pop;
  logic             young;
  logic             hit_young;
  logic             hit_old;

  assign bus.in_ready = (count != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count != 2'd0) && !bus.rf_wstall;
  assign bus.rf_we    = pop;
  assign bus.rf_waddr = mem_dest[head];
  assign bus.rf_wdata = mem_result[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_result[i] <= '0;
        mem_dest[i]   <= '0;
      end
    end else begin
      if (push) begin
        mem_result[tail] <= bus.in_result;
        mem_dest[tail]   <= bus.in_dest;
        tail             <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // With two entries the one behind the tail is the younger; with one it is also the head.
  always_comb begin
    young          = ~tail;
    hit_young      = (count != 2'd0) && (mem_dest[young] == bus.query_addr);
    hit_old        = (count == 2'd2) && (mem_dest[head] == bus.query_addr);
    bus.query_hit  = hit_young || hit_old;
    bus.query_data = '0;
    if (hit_young) begin
      bus.query_data = mem_result[young];
    end else if (hit_old) begin
      bus.query_data = mem_result[head];
    end
  end

`ifdef SHIFT_WRITEBACK_FLAGS_EN
  logic       mem_c [2];
  logic [3:0] shamt_m1;
  logic       carry_in;
  logic       fz_q;
  logic       fn_q;
  logic       fc_q;
  logic       fv_q;

  // Carry is the last bit shifted out, captured while the unshifted operand is still available.
  assign shamt_m1 = bus.in_shamt - 4'd1;
  assign carry_in = (bus.in_shamt != 4'd0) ? bus.in_operand[shamt_m1] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_c[0] <= 1'b0;
      mem_c[1] <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_c[tail] <= carry_in;
      end
      fv_q <= pop;
      if (pop) begin
        fz_q <= (mem_result[head] == '0);
        fn_q <= mem_result[head][WIDTH-1];
        fc_q <= mem_c[head];
      end
    end
  end

  assign bus.flag_z     = fz_q;
  assign bus.flag_n     = fn_q;
  assign bus.flag_c     = fc_q;
  assign bus.flag_valid = fv_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{bus.in_operand, bus.in_shamt};
  assign bus.flag_z     = 1'b0;
  assign bus.flag_n     = 1'b0;
  assign bus.flag_c     = 1'b0;
  assign bus.flag_valid = 1'b0;
`endif
endmodule

// File: tb/tb_shift_writeback_buffer.sv
// tb/tb_shift_writeback_buffer.sv - scoreboard bench for the shift writeback buffer
module tb_shift_writeback_buffer;
  logic clk;
  logic reset;
  int   test_cnt = 0;
  int   fail_cnt = 0;
  int   cyc = 0;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    logic        z;
    logic        n;
    logic        c;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        wr_cycles[$];
  logic      exp_fv = 1'b0;
  logic      exp_z  = 1'b0;
  logic      exp_n  = 1'b0;
  logic      exp_c  = 1'b0;

`ifdef SHIFT_WRITEBACK_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  shift_writeback_buffer_if #(.WIDTH(16), .AW(3)) bus ();

  shift_writeback_buffer #(.WIDTH(16), .AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit monitor: flags checked one cycle after the write that produced them.
  always @(negedge clk) begin
    check_eq("flag_valid", {31'd0, bus.flag_valid}, {31'd0, exp_fv});
    check_eq("flag_z", {31'd0, bus.flag_z}, {31'd0, exp_z});
    check_eq("flag_n", {31'd0, bus.flag_n}, {31'd0, exp_n});
    check_eq("flag_c", {31'd0, bus.flag_c}, {31'd0, exp_c});
    if (reset) begin
      sb.delete();
      exp_fv <= 1'b0;
      exp_z  <= 1'b0;
      exp_n  <= 1'b0;
      exp_c  <= 1'b0;
    end else begin
      exp_fv <= 1'b0;
      if (bus.rf_we) begin
        wr_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          check_eq("spurious_write", {31'd0, bus.rf_we}, 32'd0);
        end else begin
          check_eq("rf_waddr", {29'd0, bus.rf_waddr}, {29'd0, sb[0].dest});
          check_eq("rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, sb[0].data});
          if (FLAGS_ON) begin
            exp_fv <= 1'b1;
            exp_z  <= sb[0].z;
            exp_n  <= sb[0].n;
            exp_c  <= sb[0].c;
          end
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_entry(input logic [2:0] dest, input logic [15:0] op, input logic [3:0] sh);
    sb_entry_t e;
    int        guard;
    guard          = 0;
    bus.in_valid   = 1'b1;
    bus.in_dest    = dest;
    bus.in_operand = op;
    bus.in_shamt   = sh;
    bus.in_result  = op >> sh;
    @(negedge clk);
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check_eq("push_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      e.dest = dest;
      e.data = op >> sh;
      e.z    = ((op >> sh) == 16'd0);
      e.n    = e.data[15];
      e.c    = (sh != 4'd0) ? op[sh - 4'd1] : 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_result  = '0;
    bus.in_operand = '0;
    bus.in_shamt   = '0;
    bus.in_dest    = '0;
    bus.rf_wstall  = 1'b0;
    bus.query_addr = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check_eq("rst_query_hit", {31'd0, bus.query_hit}, 32'd0);
    check_eq("rst_rf_waddr", {29'd0, bus.rf_waddr}, 32'd0);
    check_eq("rst_rf_wdata", {16'd0, bus.rf_wdata}, 32'd0);
    check_eq("rst_query_data", {16'd0, bus.query_data}, 32'd0);

    // Single write: commit the cycle after the push, flags one cycle later.
    push_entry(3'd3, 16'h8001, 4'd1);
    @(negedge clk);
    check_eq("single_we", {31'd0, bus.rf_we}, 32'd1);
    check_eq("single_waddr", {29'd0, bus.rf_waddr}, 32'd3);
    check_eq("single_wdata", {16'd0, bus.rf_wdata}, 32'h4000);
    @(negedge clk);
    check_eq("single_fv", {31'd0, bus.flag_valid}, {31'd0, FLAGS_ON});
    check_eq("single_fc", {31'd0, bus.flag_c}, {31'd0, FLAGS_ON});
    drain();

    // An in-flight push is not forwarded to the bypass.
    bus.in_valid   = 1'b1;
    bus.in_dest    = 3'd6;
    bus.in_result  = 16'h1234;
    bus.query_addr = 3'd6;
    #1;
    check_eq("no_forward", {31'd0, bus.query_hit}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Stall and full.
    bus.rf_wstall = 1'b1;
    push_entry(3'd1, 16'h0011, 4'd0);
    push_entry(3'd2, 16'h0022, 4'd0);
    @(negedge clk);
    check_eq("full_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("full_we", {31'd0, bus.rf_we}, 32'd0);
    @(posedge clk);
    #1;
    bus.rf_wstall = 1'b0;
    bus.query_addr = 3'd1;
    @(negedge clk);
    check_eq("release_we1", {31'd0, bus.rf_we}, 32'd1);
    check_eq("release_ready1", {31'd0, bus.in_ready}, 32'd0);
    check_eq("commit_still_hits", {31'd0, bus.query_hit}, 32'd1);
    @(negedge clk);
    check_eq("release_we2", {31'd0, bus.rf_we}, 32'd1);
    check_eq("release_ready2", {31'd0, bus.in_ready}, 32'd1);
    drain();

    // Bypass picks the youngest of two matching entries.
    bus.rf_wstall = 1'b1;
    push_entry(3'd5, 16'h00AA, 4'd0);
    push_entry(3'd5, 16'h00BB, 4'd0);
    bus.query_addr = 3'd5;
    #1;
    check_eq("bypass_hit", {31'd0, bus.query_hit}, 32'd1);
    check_eq("bypass_data", {16'd0, bus.query_data}, 32'h00BB);
    bus.query_addr = 3'd4;
    #1;
    check_eq("bypass_miss", {31'd0, bus.query_hit}, 32'd0);
    bus.rf_wstall = 1'b0;
    drain();

    // Throughput with pointer wrap.
    wr_cycles.delete();
    for (int i = 0; i < 6; i++) begin
      push_entry(3'(i), 16'h0100 + 16'(i * 16'h0111), 4'(i));
    end
    drain();
    check_eq("tput_writes", wr_cycles.size(), 32'd6);
    if (wr_cycles.size() == 6) begin
      check_eq("tput_span", 32'(wr_cycles[5] - wr_cycles[0]), 32'd5);
    end

    // Carry boundaries; the n=1 case is committed last so reset must clear it.
    push_entry(3'd7, 16'h8000, 4'd15);
    push_entry(3'd6, 16'h0001, 4'd4);
    push_entry(3'd0, 16'h8000, 4'd0);
    drain();
    check_eq("n_before_reset", {31'd0, bus.flag_n}, {31'd0, FLAGS_ON});

    // Reset with two entries pending under stall.
    bus.rf_wstall = 1'b1;
    push_entry(3'd7, 16'h0077, 4'd0);
    push_entry(3'd6, 16'h0066, 4'd0);
    bus.query_addr = 3'd7;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
    check_eq("mid_rst_hit", {31'd0, bus.query_hit}, 32'd0);
    check_eq("mid_rst_fz", {31'd0, bus.flag_z}, 32'd0);
    check_eq("mid_rst_fn", {31'd0, bus.flag_n}, 32'd0);
    check_eq("mid_rst_fc", {31'd0, bus.flag_c}, 32'd0);
    check_eq("mid_rst_fv", {31'd0, bus.flag_valid}, 32'd0);
    bus.rf_wstall = 1'b0;
    wr_cycles.delete();
    repeat (6) @(posedge clk);
    #1;
    check_eq("no_stale_write", wr_cycles.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_writeback_buffer.md
# shift_writeback_buffer

Two-entry buffered writeback stage directly downstream of the variable logical-shift-right unit. Accepts each shift result with its destination register index and writes it to the register file write port, holding entries while the port is stalled. Exposes a bypass lookup so the operand-fetch stage can read still-pending results. Optionally produces zero, negative and carry flags for each committed result.

## Interface

**Parameters**
- `WIDTH`, 16: data width of the result and operand.
- `AW`, 3: register index width (8 registers).

**Ports**
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: a shift result is presented.
- `in_ready`, output, 1: the buffer accepts an entry this cycle.
- `in_result`, input, WIDTH: the shifter output (`in_operand >> in_shamt`).
- `in_operand`, input, WIDTH: the unshifted operand, used only for the carry flag.
- `in_shamt`, input, 4: the shift amount, equal to the 4 LSBs of the register-file value.
- `in_dest`, input, AW: the destination register index.
- `rf_wstall`, input, 1: the register file write port is busy this cycle.
- `rf_we`, output, 1: register file write enable.
- `rf_waddr`, output, AW: register file write address.
- `rf_wdata`, output, WIDTH: register file write data.
- `query_addr`, input, AW: the register index being fetched upstream.
- `query_hit`, output, 1: a pending entry targets `query_addr`.
- `query_data`, output, WIDTH: the result of the youngest matching entry.
- `flag_z`, output, 1: zero flag of the last committed result.
- `flag_n`, output, 1: negative flag of the last committed result.
- `flag_c`, output, 1: carry flag of the last committed result.
- `flag_valid`, output, 1: one-cycle pulse when the flags update.

Clock `clk`; reset synchronous, active-high, port `reset`.

## Operation

**Storage**
- 2-entry FIFO. Each entry holds `result`, `dest`, and, when flags are enabled, precomputed `c`.
- Occupancy `count` is 0..2. Head and tail pointers are 1 bit each and wrap 1→0.

**Push**
- A push occurs when `in_valid && in_ready`.
- `in_ready = (count != 2)`. It is purely a function of the registered count and does not depend on a same-cycle pop.

**Commit**
- `rf_we = (count != 0) && !rf_wstall`, combinational.
- `rf_waddr` and `rf_wdata` always present the head entry; they are don't-care when `count == 0`, but are driven as the head contents.
- When `rf_we` is high, the head entry is popped at the clock edge.

**Simultaneous push and pop**
- Push and pop in the same cycle leave `count` unchanged.
- Both pointers advance.

**Bypass**
- `query_hit` is 1 when any valid entry has `dest == query_addr`.
- `query_data` returns the youngest match: the tail-1 entry takes priority over the head.
- Bypass is combinational from the stored entries only. A same-cycle `in_*` is not forwarded.
- An entry being committed this cycle still hits.

**Carry computation at push**
- `c = (in_shamt != 0) ? in_operand[in_shamt-1] : 0`.

**Reset**
- Sets `count`, head and tail to 0.
- All pending entries are discarded, including any entry mid-commit.
- Flags and `flag_valid` are set to 0.

## Timing

- Push in cycle N. The earliest `rf_we` for that entry is in cycle N+1, and the write completes at the end of N+1.
- An empty buffer with a push every cycle and no stall sustains one write per cycle.
- While `rf_wstall` is held, the buffer fills after 2 pushes and `in_ready` drops in the following cycle.
- `in_ready` rises in the cycle after the first pop from a full buffer.
- Flags and `flag_valid` are registered. They are updated at the edge that commits an entry, so they are visible in the cycle after `rf_we`.
- `flag_valid` is high for exactly one cycle per commit.
- Reset values: `in_ready`=1, `rf_we`=0, `query_hit`=0, `rf_waddr`=0, `rf_wdata`=0, `query_data`=0, `flag_z`=0, `flag_n`=0, `flag_c`=0, `flag_valid`=0.

## Configuration

- **Macro `SHIFT_WRITEBACK_FLAGS_EN` defined:**
  - The per-entry `c` bit is stored.
  - On commit: `flag_z = (result == 0)`, `flag_n = result[WIDTH-1]`, `flag_c = entry.c`.
  - `flag_valid` pulses as specified under Timing.
- **Macro not defined:**
  - No flag storage or logic is built.
  - `flag_z`, `flag_n`, `flag_c` and `flag_valid` are tied to 0.
  - `in_operand` and `in_shamt` are unused.
  - All other behaviour is identical.

## Test plan

- **Single write.** Push result=0x4000, dest=3, operand=0x8001, shamt=1 with no stall → `rf_we`=1 with waddr=3, wdata=0x4000 in the next cycle; then `flag_c`=1, `flag_z`=0, `flag_n`=0, `flag_valid` pulses once (flags build).
- **Stall and full.** Hold `rf_wstall`=1 and push dest=1/0x0011, then dest=2/0x0022 → `in_ready`=0, `rf_we`=0. Release the stall → writes to r1 then r2 on consecutive cycles; `in_ready` returns to 1 after the first write.
- **Bypass youngest.** Stall the port and push dest=5/0x00AA, then dest=5/0x00BB; query 5 → `query_hit`=1, `query_data`=0x00BB. Query 4 → `query_hit`=0.
- **Carry boundaries.**
  - operand=0x8000, shamt=0, result 0x8000 → `flag_n`=1, `flag_c`=0.
  - operand=0x8000, shamt=15, result 0x0001 → `flag_c`=0.
  - operand=0x0001, shamt=4, result 0x0000 → `flag_z`=1, `flag_c`=0.
- **Throughput with wrap.** 6 back-to-back pushes, no stall → 6 writes on consecutive cycles in order; pointers wrap without loss.
- **Reset mid-operation.** With 2 entries pending under stall, assert `reset` for one cycle → `count`=0, `in_ready`=1, `rf_we`=0, `query_hit`=0, all flags 0; no stale write occurs after the stall is released.
